// File: rtl/pla_inverse_search_pkg.sv
// Shared definitions for the PLA inverse-lookup engine: default sizes,
// FSM state encoding and the cube-slot record.
package pla_inverse_search_pkg;

  localparam int PLA_NI    = 10;
  localparam int PLA_NO    = 12;
  localparam int PLA_NCUBE = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  // One product term: AND-plane literals (mask/val) plus its OR-plane row.
  typedef struct packed {
    logic              en;
    logic [PLA_NI-1:0] mask;
    logic [PLA_NI-1:0] val;
    logic [PLA_NO-1:0] out;
  } cube_t;

endpackage

// File: rtl/pla_inverse_search_if.sv
// Configuration, request and response channels of the PLA inverse-lookup engine.
interface pla_inverse_search_if
  import pla_inverse_search_pkg::*;
#(
  parameter int NI = PLA_NI,
  parameter int NO = PLA_NO,
  parameter int CW = $clog2(PLA_NCUBE)
);
  logic          cfg_we;
  logic          cfg_ready;
  logic [CW-1:0] cfg_addr;
  logic          cfg_en;
  logic [NI-1:0] cfg_mask;
  logic [NI-1:0] cfg_val;
  logic [NO-1:0] cfg_out;
  logic          req_valid;
  logic          req_ready;
  logic [NO-1:0] req_target;
  logic [NO-1:0] req_care;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_found;
  logic [NI-1:0] rsp_x;

  modport master (
    output cfg_we, cfg_addr, cfg_en, cfg_mask, cfg_val, cfg_out,
    output req_valid, req_target, req_care, rsp_ready,
    input  cfg_ready, req_ready, rsp_valid, rsp_found, rsp_x
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_en, cfg_mask, cfg_val, cfg_out,
    input  req_valid, req_target, req_care, rsp_ready,
    output cfg_ready, req_ready, rsp_valid, rsp_found, rsp_x
  );
endinterface

// File: rtl/pla_inverse_search_cube_eval.sv
// Combinational two-level PLA evaluation: cube table + input vector -> f(x).
module pla_inverse_search_cube_eval
  import pla_inverse_search_pkg::*;
#(
  parameter int NCUBE = PLA_NCUBE
) (
  input  cube_t             i_cubes [NCUBE],
  input  logic [PLA_NI-1:0] i_x,
  output logic [PLA_NO-1:0] o_f
);

  // A cube hits when every cared literal agrees with x; hits OR their rows.
  always_comb begin
    o_f = '0;
    for (int c = 0; c < NCUBE; c++) begin
      if (i_cubes[c].en && (((i_x ^ i_cubes[c].val) & i_cubes[c].mask) == '0)) begin
        o_f = o_f | i_cubes[c].out;
      end
    end
  end

endmodule

// File: rtl/pla_inverse_search.sv
// Sequential inverse lookup: scans x = 0 .. 2^NI-1 and reports the lowest x
// whose PLA output matches the masked target.
module pla_inverse_search
  import pla_inverse_search_pkg::*;
#(
  parameter int NI    = PLA_NI,
  parameter int NO    = PLA_NO,
  parameter int NCUBE = PLA_NCUBE
) (
  input logic                clk,
  input logic                rst,
  pla_inverse_search_if.slave bus
);

  localparam int CW = $clog2(NCUBE);

  cube_t         r_cubes [NCUBE];
  state_t        r_state;
  logic [NI-1:0] r_cand;
  logic [NI-1:0] r_rsp_x;
  logic          r_rsp_found;
  logic [NO-1:0] r_target;
  logic [NO-1:0] r_care;

  logic [CW-1:0] w_addr;
  logic [NO-1:0] w_f;
  logic          w_idle;
  logic          w_match;
  logic          w_last;

  assign w_addr  = bus.cfg_addr;
  assign w_idle  = (r_state == IDLE);
  assign w_match = (((w_f ^ r_target) & r_care) == '0);
  assign w_last  = (r_cand == {NI{1'b1}});

  assign bus.cfg_ready = w_idle;
  assign bus.req_ready = w_idle;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_found = r_rsp_found;
  assign bus.rsp_x     = r_rsp_x;

  // Only the slot-valid bits are cleared; literal/row data is don't-care while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCUBE; c++) begin
        r_cubes[c].en <= 1'b0;
      end
    end else if (bus.cfg_we && w_idle) begin
      r_cubes[w_addr] <= {bus.cfg_en, bus.cfg_mask, bus.cfg_val, bus.cfg_out};
    end
  end

  pla_inverse_search_cube_eval #(.NCUBE(NCUBE)) u_eval (
    .i_cubes (r_cubes),
    .i_x     (r_cand),
    .o_f     (w_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_rsp_found <= 1'b0;
      r_rsp_x     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_target <= bus.req_target;
            r_care   <= bus.req_care;
            r_cand   <= '0;
            r_state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_match) begin
            r_rsp_x     <= r_cand;
            r_rsp_found <= 1'b1;
            r_state     <= RESP;
          end else if (w_last) begin
            r_rsp_x     <= {NI{1'b1}};
            r_rsp_found <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_cand <= r_cand + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
